// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared constants and helpers for the data memory block.
//   Region decode : maddr[31:28] selects the register region when it equals
//                   the MMIO tag; anything else is RAM.
//   Register map  : CYC 0x0, RDCNT 0x4, WRCNT 0x8, CTRL 0xC. Any other offset
//                   is an error access.
package dmem_pkg;

  localparam int REGION_W   = 4;
  localparam int MMIO_OFF_W = 32 - REGION_W;

  localparam logic [REGION_W-1:0] MMIO_TAG_DEFAULT = 4'hF;

  localparam logic [MMIO_OFF_W-1:0] OFF_CYC   = 28'h0;
  localparam logic [MMIO_OFF_W-1:0] OFF_RDCNT = 28'h4;
  localparam logic [MMIO_OFF_W-1:0] OFF_WRCNT = 28'h8;
  localparam logic [MMIO_OFF_W-1:0] OFF_CTRL  = 28'hC;

  typedef enum logic [1:0] {
    REG_CYC,
    REG_RDCNT,
    REG_WRCNT,
    REG_CTRL
  } mmio_reg_e;

  // Offsets above CTRL are errors. Misaligned offsets below it are caught by
  // the separate alignment check, so only the upper bound matters here.
  function automatic logic mmio_off_valid(input logic [MMIO_OFF_W-1:0] off);
    return off <= OFF_CTRL;
  endfunction

  function automatic mmio_reg_e mmio_reg_sel(input logic [MMIO_OFF_W-1:0] off);
    case (off)
      OFF_RDCNT: return REG_RDCNT;
      OFF_WRCNT: return REG_WRCNT;
      OFF_CTRL:  return REG_CTRL;
      default:   return REG_CYC;
    endcase
  endfunction

endpackage

// File: rtl/dmem_counters.sv
// dmem_counters -- activity counters and sticky error flag for dmem.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-low reset
//   rd_hit   : a non-error read completes this cycle
//   wr_hit   : a non-error write completes this cycle
//   clr      : CTRL write this cycle; zeroes everything and wins over increments
//   err_hit  : an error access occurs this cycle
//   cyc      : free-running cycle count (wraps)
//   rdcnt    : completed read count (saturating)
//   wrcnt    : completed write count (saturating)
//   err      : sticky error flag
module dmem_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_hit,
  input  logic        wr_hit,
  input  logic        clr,
  input  logic        err_hit,
  output logic [31:0] cyc,
  output logic [31:0] rdcnt,
  output logic [31:0] wrcnt,
  output logic        err
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc   <= '0;
      rdcnt <= '0;
      wrcnt <= '0;
      err   <= 1'b0;
    end else if (clr) begin
      cyc   <= '0;
      rdcnt <= '0;
      wrcnt <= '0;
      err   <= 1'b0;
    end else begin
      cyc <= cyc + 32'd1;
      if (rd_hit && (rdcnt != 32'hFFFF_FFFF)) rdcnt <= rdcnt + 32'd1;
      if (wr_hit && (wrcnt != 32'hFFFF_FFFF)) wrcnt <= wrcnt + 32'd1;
      // clr only comes from a non-error write, so it never meets err_hit.
      if (err_hit) err <= 1'b1;
    end
  end

endmodule

// File: rtl/dmem.sv
// dmem -- single-port data memory for a single-cycle CPU with a small
// register region for activity counters.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-low reset (RAM contents are kept)
//   DM_CS  : access enable
//   DM_R   : read request (qualified by DM_CS)
//   DM_W   : write request (qualified by DM_CS)
//   maddr  : byte address
//   mwdata : write data
//   mrdata : combinational read data, 0 when idle or on an error access
//   err    : sticky error flag
// DEPTH_WORDS must be a power of two and at least 2.
module dmem
  import dmem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [REGION_W-1:0] MMIO_TAG = MMIO_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] maddr,
  input  logic [31:0] mwdata,
  output logic [31:0] mrdata,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];

  logic                  is_mmio;
  logic [MMIO_OFF_W-1:0] mmio_off;
  mmio_reg_e             reg_sel;
  logic [AW-1:0]         word_idx;
  logic                  misaligned;
  logic                  ram_oob;
  logic                  mmio_bad;
  logic                  acc_err;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  ctrl_clr;
  logic [31:0]           cyc;
  logic [31:0]           rdcnt;
  logic [31:0]           wrcnt;

  assign is_mmio  = (maddr[31:MMIO_OFF_W] == MMIO_TAG);
  assign mmio_off = maddr[MMIO_OFF_W-1:0];
  assign reg_sel  = mmio_reg_sel(mmio_off);
  assign word_idx = maddr[AW+1:2];

  // The RAM bound uses the full address so RAM-region addresses with high
  // bits set are rejected rather than aliased onto the array.
  assign misaligned = (maddr[1:0] != 2'b00);
  assign ram_oob    = !is_mmio && ({1'b0, maddr} >= RAM_BYTES);
  assign mmio_bad   = is_mmio && !mmio_off_valid(mmio_off);
  assign acc_err    = DM_CS && (misaligned || ram_oob || mmio_bad);

  assign rd_ok    = DM_CS && DM_R && !acc_err;
  assign wr_ok    = DM_CS && DM_W && !acc_err;
  assign ctrl_clr = wr_ok && is_mmio && (reg_sel == REG_CTRL);

  // Writes to the read-only counters are accepted silently; only RAM
  // writes touch the array, and a reset cycle discards them.
  always_ff @(posedge clk) begin
    if (reset && wr_ok && !is_mmio) mem[word_idx] <= mwdata;
  end

  // Read shows the contents before any same-cycle write. While reset is
  // held, register reads show the values the registers are about to take.
  always_comb begin
    mrdata = '0;
    if (rd_ok) begin
      if (!is_mmio) begin
        mrdata = mem[word_idx];
      end else if (reset) begin
        case (reg_sel)
          REG_CYC:   mrdata = cyc;
          REG_RDCNT: mrdata = rdcnt;
          REG_WRCNT: mrdata = wrcnt;
          REG_CTRL:  mrdata = {31'b0, err};
          default:   mrdata = '0;
        endcase
      end
    end
  end

  dmem_counters u_counters (
    .clk     (clk),
    .reset   (reset),
    .rd_hit  (rd_ok),
    .wr_hit  (wr_ok),
    .clr     (ctrl_clr),
    .err_hit (acc_err),
    .cyc     (cyc),
    .rdcnt   (rdcnt),
    .wrcnt   (wrcnt),
    .err     (err)
  );

endmodule

// File: tb/tb_dmem.sv
module tb_dmem;

  localparam int         DEPTH = 256;
  localparam logic [3:0] TAG   = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic        DM_CS, DM_R, DM_W;
  logic [31:0] maddr, mwdata, mrdata;
  logic        err;

  dmem #(.DEPTH_WORDS(DEPTH), .MMIO_TAG(TAG)) dut (
    .clk    (clk),
    .reset  (reset),
    .DM_CS  (DM_CS),
    .DM_R   (DM_R),
    .DM_W   (DM_W),
    .maddr  (maddr),
    .mwdata (mwdata),
    .mrdata (mrdata),
    .err    (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: memory as a sparse map of written words, plus the four
  // architectural registers.
  logic [31:0] m_mem [int];
  bit   [31:0] m_cyc, m_rd, m_wr;
  bit          m_err;

  function automatic bit is_mmio_addr(input logic [31:0] a);
    return (a >> 28) == 32'(TAG);
  endfunction

  function automatic bit is_err_acc(input bit cs, input logic [31:0] a);
    if (!cs) return 1'b0;
    if (a % 4 != 0) return 1'b1;
    if (is_mmio_addr(a)) return (a & 32'h0FFF_FFFF) > 32'hC;
    return a >= DEPTH * 4;
  endfunction

  // Expected read data for the inputs currently applied; returns 0 when the
  // value is unknowable (RAM word never written).
  function automatic bit exp_rd(output logic [31:0] v);
    logic [31:0] off;
    v = '0;
    if (!(DM_CS && DM_R) || is_err_acc(DM_CS, maddr)) return 1'b1;
    if (!is_mmio_addr(maddr)) begin
      if (!m_mem.exists(int'(maddr / 4))) return 1'b0;
      v = m_mem[int'(maddr / 4)];
      return 1'b1;
    end
    if (!reset) return 1'b1;
    off = maddr & 32'h0FFF_FFFF;
    if (off == 0)      v = m_cyc;
    else if (off == 4) v = m_rd;
    else if (off == 8) v = m_wr;
    else               v = {31'b0, m_err};
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit e;
    e = is_err_acc(DM_CS, maddr);
    if (!reset) begin
      m_cyc = 0; m_rd = 0; m_wr = 0; m_err = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (DM_CS && DM_R && !e && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
      if (DM_CS && DM_W && !e) begin
        if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
        if (!is_mmio_addr(maddr)) m_mem[int'(maddr / 4)] = mwdata;
        else if ((maddr & 32'h0FFF_FFFF) == 32'hC) begin
          m_cyc = 0; m_rd = 0; m_wr = 0; m_err = 0;
        end
      end
      if (e) m_err = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t addr=%h)", name, act, exp, $time, maddr);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] v;
    if (chk_en) begin
      if (exp_rd(v)) check("mrdata", mrdata, v);
      check("err", {31'b0, err}, {31'b0, m_err});
    end
  end

  task automatic drive(input bit cs, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    DM_CS = cs; DM_R = r; DM_W = w; maddr = a; mwdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Literal check of settled outputs, a few ns after the inputs change.
  task automatic lit(input string name, input logic [31:0] exp);
    #3;
    check(name, mrdata, exp);
  endtask

  task automatic rand_access();
    logic [31:0] a;
    int sel;
    case ($urandom_range(9))
      0, 1, 2, 3, 4: begin
        sel = $urandom_range(1) ? $urandom_range(15) : DEPTH - 1 - $urandom_range(3);
        a = 32'(sel) * 4;
      end
      5: a = 32'($urandom_range(63)) * 4 + 32'($urandom_range(3, 1));
      6: a = $urandom_range(1) ? 32'(DEPTH * 4) + 32'($urandom_range(15)) * 4
                              : ($urandom() & 32'hEFFF_FFFC);
      7, 8: a = {TAG, 28'($urandom_range(3) * 4)};
      default: a = {TAG, 28'(16 + $urandom_range(255) * 4)};
    endcase
    drive($urandom_range(9) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)), a, $urandom());
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    chk_en = 1'b1;
    // Register read during reset returns the reset value.
    drive(1, 1, 0, 32'hF000_0000, 0);
    lit("cyc_in_reset", 32'h0);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();

    // Write then read back.
    drive(1, 0, 1, 32'h0000_0010, 32'hDEADBEEF);
    step();
    drive(1, 1, 0, 32'h0000_0010, 0);
    lit("rd_after_wr", 32'hDEADBEEF);
    step();
    drive(1, 1, 0, 32'hF000_0004, 0);
    lit("rdcnt_1", 32'd1);
    step();
    drive(1, 1, 0, 32'hF000_0008, 0);
    lit("wrcnt_1", 32'd1);
    step();

    // Simultaneous read and write shows old data, then new.
    drive(1, 1, 1, 32'h0000_0010, 32'h1234_5678);
    lit("rw_old", 32'hDEADBEEF);
    step();
    drive(1, 1, 0, 32'h0000_0010, 0);
    lit("rw_new", 32'h1234_5678);
    step();

    // Misaligned write is suppressed and flags err.
    drive(1, 0, 1, 32'h0000_0012, 32'hAAAA_5555);
    step();
    drive(1, 1, 0, 32'h0000_0010, 0);
    lit("misaligned_no_write", 32'h1234_5678);
    check("err_set", {31'b0, err}, 32'd1);
    step();
    drive(1, 1, 0, 32'hF000_0008, 0);
    lit("wrcnt_unchanged", 32'd2);
    step();
    drive(1, 1, 0, 32'hF000_000C, 0);
    lit("ctrl_err", 32'd1);
    step();

    // Saturation of WRCNT.
    drive(0, 0, 0, 0, 0);
    force dut.u_counters.wrcnt = 32'hFFFF_FFFE;
    m_wr = 32'hFFFF_FFFE;
    #1 release dut.u_counters.wrcnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 32'h40 + 32'(i) * 4, 32'h100 + 32'(i));
      step();
    end
    drive(1, 1, 0, 32'hF000_0008, 0);
    lit("wrcnt_sat", 32'hFFFF_FFFF);
    step();

    // CYC wrap.
    force dut.u_counters.cyc = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    #1 release dut.u_counters.cyc;
    drive(1, 1, 0, 32'hF000_0000, 0);
    lit("cyc_max", 32'hFFFF_FFFF);
    step();
    drive(1, 1, 0, 32'hF000_0000, 0);
    lit("cyc_wrap", 32'h0);
    step();

    // CTRL clear while err=1 and counters non-zero.
    drive(1, 0, 1, 32'hF000_000C, 32'h5A5A_5A5A);
    step();
    drive(1, 1, 0, 32'hF000_0000, 0);
    lit("clr_cyc", 32'h0);
    check("clr_err", {31'b0, err}, 32'd0);
    step();
    drive(1, 0, 1, 32'hF000_000C, 0);
    step();
    drive(1, 1, 0, 32'hF000_0004, 0);
    lit("clr_rdcnt", 32'h0);
    step();
    drive(1, 1, 0, 32'hF000_0008, 0);
    lit("clr_wrcnt", 32'h0);
    step();

    // Reset in the middle of a write burst to 0x20.
    drive(1, 1, 0, 32'h0000_0003, 0);
    step();
    drive(1, 0, 1, 32'h0000_0020, 32'h1111_1111);
    step();
    drive(1, 0, 1, 32'h0000_0020, 32'h2222_2222);
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(1, 1, 0, 32'hF000_0000, 0);
    lit("rst_cyc", 32'h0);
    check("rst_err", {31'b0, err}, 32'd0);
    step();
    drive(1, 1, 0, 32'hF000_0008, 0);
    lit("rst_wrcnt", 32'h0);
    step();
    drive(1, 1, 0, 32'h0000_0020, 0);
    lit("rst_no_write", 32'h1111_1111);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(63) != 0);
      rand_access();
      step();
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
